mac_seq_ctrl: RTL and testbench

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_mac_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// Sequencer for a matrix-vector multiply on an external MAC.
// For each of ROWS rows it clears the MAC, streams VEC_LEN operand pairs from
// the two memories, waits for the last product to land, then presents the
// dot product through a valid/ready handshake.
module mac_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 4,
    parameter int ROWS       = 2,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   a_addr,
    output logic [ADDR_WIDTH-1:0]   b_addr,
    output logic                    rd_en,
    input  logic [DATA_WIDTH-1:0]   a_rdata,
    input  logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    mac_en,
    output logic                    mac_clr,
    output logic [DATA_WIDTH-1:0]   mac_ain,
    output logic [DATA_WIDTH-1:0]   mac_bin,
    input  logic [3*DATA_WIDTH-1:0] mac_cout,
    output logic [3*DATA_WIDTH-1:0] result,
    output logic                    result_valid,
    input  logic                    result_ready
);

    localparam int KW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        RESULT
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [RW-1:0]   r_q, r_d;
    logic            last_k;
    logic            last_r;
    logic            handshake;
    logic [ADDR_WIDTH-1:0] row_base;

    assign last_k    = (k_q == KW'(VEC_LEN - 1));
    assign last_r    = (r_q == RW'(ROWS - 1));
    assign handshake = (state_q == RESULT) && result_ready;
    assign row_base  = ADDR_WIDTH'(r_q) * ADDR_WIDTH'(VEC_LEN);

    // State, row and element counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            r_q     <= r_d;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        r_d     = r_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    r_d     = '0;
                end
            end
            CLEAR: begin
                k_d     = '0;
                state_d = RUN;
            end
            RUN: begin
                k_d = last_k ? '0 : k_q + 1'b1;
                if (last_k) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = RESULT;
            end
            RESULT: begin
                if (result_ready) begin
                    if (last_r) begin
                        state_d = IDLE;
                    end else begin
                        r_d     = r_q + 1'b1;
                        state_d = CLEAR;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded directly from the current state.
    always_comb begin
        busy         = (state_q != IDLE);
        mac_clr      = (state_q == CLEAR);
        result_valid = (state_q == RESULT);
        result       = (state_q == RESULT) ? mac_cout : '0;
        mac_ain      = a_rdata;
        mac_bin      = b_rdata;
    end

    // Registered read strobe and addresses are computed from the next state and
    // next element index, so they line up with the RUN cycle that issues them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en  <= 1'b0;
            a_addr <= '0;
            b_addr <= '0;
            mac_en <= 1'b0;
            done   <= 1'b0;
        end else begin
            rd_en  <= (state_d == RUN);
            a_addr <= (state_d == RUN) ? row_base + ADDR_WIDTH'(k_d) : '0;
            b_addr <= (state_d == RUN) ? ADDR_WIDTH'(k_d) : '0;
            mac_en <= rd_en;
            done   <= handshake && last_r;
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl with behavioural memories and MAC.
module tb_mac_seq_ctrl;

    localparam int DW = 8;
    localparam int VL = 4;
    localparam int RS = 2;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic          rd_en;
    logic [DW-1:0] a_rdata = '0;
    logic [DW-1:0] b_rdata = '0;
    logic          mac_en;
    logic          mac_clr;
    logic [DW-1:0] mac_ain;
    logic [DW-1:0] mac_bin;
    logic [3*DW-1:0] mac_cout;
    logic [3*DW-1:0] result;
    logic          result_valid;
    logic          result_ready;

    logic [7:0]  amem [0:7];
    logic [7:0]  bmem [0:3];
    logic [23:0] acc = 24'h5A5A5A;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mac_seq_ctrl #(
        .DATA_WIDTH(DW),
        .VEC_LEN(VL),
        .ROWS(RS),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .done(done),
        .a_addr(a_addr),
        .b_addr(b_addr),
        .rd_en(rd_en),
        .a_rdata(a_rdata),
        .b_rdata(b_rdata),
        .mac_en(mac_en),
        .mac_clr(mac_clr),
        .mac_ain(mac_ain),
        .mac_bin(mac_bin),
        .mac_cout(mac_cout),
        .result(result),
        .result_valid(result_valid),
        .result_ready(result_ready)
    );

    // Operand memories with one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            a_rdata <= amem[a_addr[2:0]];
            b_rdata <= bmem[b_addr[1:0]];
        end
    end

    // External MAC: not reset, so stale contents survive a sequencer reset.
    always @(posedge clk) begin
        if (mac_clr)
            acc <= '0;
        else if (mac_en)
            acc <= acc + 24'(mac_ain) * 24'(mac_bin);
    end
    assign mac_cout = acc;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [31:0] b;
        logic [23:0] e0;
        logic [23:0] e1;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input int i);
        for (int j = 0; j < 8; j++) amem[j] = tbl[i].a[8*j +: 8];
        for (int j = 0; j < 4; j++) bmem[j] = tbl[i].b[8*j +: 8];
    endtask

    // One complete job; start is raised in cycle 0.
    task automatic run_job(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                           input int hold, input bit poke, input bit timing);
        int  c;
        int  row;
        int  nrd;
        int  hold_left;
        int  ndone;
        int  done_cyc;
        int  first_rd;
        int  first_mac;
        int  fv0;
        int  fv1;
        bit  prev_valid;
        bit  finished;
        row = 0; nrd = 0; hold_left = hold; ndone = 0; done_cyc = -1;
        first_rd = -1; first_mac = -1; fv0 = -1; fv1 = -1;
        prev_valid = 1'b0; finished = 1'b0;
        result_ready = (hold == 0);
        @(negedge clk);
        start = 1'b1;
        c = 0;
        while (c < 200 && !finished) begin
            @(negedge clk);
            c++;
            start = poke && (c == 4);
            if (timing && c == 1) begin
                check({tag, "_busy_c1"}, 32'(busy), 32'd1);
                check({tag, "_clr_c1"}, 32'(mac_clr), 32'd1);
            end
            if (rd_en) begin
                if (first_rd < 0) first_rd = c;
                check({tag, "_a_addr"}, 32'(a_addr), 32'(nrd));
                check({tag, "_b_addr"}, 32'(b_addr), 32'(nrd % VL));
                nrd++;
            end
            if (mac_en && first_mac < 0) first_mac = c;
            if (result_valid) begin
                if (!prev_valid) begin
                    if (row == 0) fv0 = c;
                    else if (row == 1) fv1 = c;
                end
                if (row == 0 && hold_left > 0) begin
                    result_ready = 1'b0;
                    hold_left--;
                    check({tag, "_hold_result"}, 32'(result), 32'(e0));
                    check({tag, "_hold_noread"}, 32'(rd_en), 32'd0);
                    prev_valid = 1'b1;
                end else begin
                    result_ready = 1'b1;
                    check({tag, (row == 0) ? "_row0" : "_row1"}, 32'(result),
                          32'((row == 0) ? e0 : e1));
                    row++;
                    prev_valid = 1'b0;
                end
            end else begin
                prev_valid = 1'b0;
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
                end
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) finished = 1'b1;
        end
        start = 1'b0;
        check({tag, "_completed"}, 32'(finished), 32'd1);
        check({tag, "_rows"}, 32'(row), 32'd2);
        check({tag, "_reads"}, 32'(nrd), 32'd8);
        check({tag, "_done_pulses"}, 32'(ndone), 32'd1);
        if (timing) begin
            check({tag, "_first_rd"}, 32'(first_rd), 32'd2);
            check({tag, "_first_mac"}, 32'(first_mac), 32'd3);
            check({tag, "_valid0_cyc"}, 32'(fv0), 32'd7);
            check({tag, "_valid1_cyc"}, 32'(fv1), 32'd14);
            check({tag, "_done_cyc"}, 32'(done_cyc), 32'd15);
        end
        if (hold > 0) begin
            check({tag, "_valid0_cyc"}, 32'(fv0), 32'd7);
            check({tag, "_valid1_cyc"}, 32'(fv1), 32'd14 + 32'(hold));
        end
    endtask

    initial begin
        int nrd;
        int c;

        tbl[0] = '{name: "seq_ones", a: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                   b: {8'd1, 8'd1, 8'd1, 8'd1}, e0: 24'd10, e1: 24'd26};
        tbl[1] = '{name: "all_ff", a: {8{8'hFF}}, b: {4{8'hFF}},
                   e0: 24'h03F804, e1: 24'h03F804};
        tbl[2] = '{name: "seq_seq", a: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                   b: {8'd4, 8'd3, 8'd2, 8'd1}, e0: 24'd30, e1: 24'd70};
        tbl[3] = '{name: "zero_row", a: {8'd2, 8'd1, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0},
                   b: {8'd5, 8'd4, 8'd3, 8'd2}, e0: 24'd0, e1: 24'd524};
        tbl[4] = '{name: "sparse_b", a: {8'd3, 8'd3, 8'd3, 8'd3, 8'd40, 8'd30, 8'd20, 8'd10},
                   b: {8'd1, 8'd0, 8'd1, 8'd0}, e0: 24'd60, e1: 24'd6};

        rst = 1'b1;
        start = 1'b0;
        result_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_a_addr", 32'(a_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            load(i);
            run_job(tbl[i].name, tbl[i].e0, tbl[i].e1, 0, 1'b0, i == 0);
        end

        load(0);
        run_job("hold", 24'd10, 24'd26, 5, 1'b0, 1'b0);
        run_job("poke", 24'd10, 24'd26, 0, 1'b1, 1'b1);

        // Reset in the middle of row 1 abandons the job.
        result_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        nrd = 0;
        c = 0;
        while (c < 100 && nrd < 6) begin
            @(negedge clk);
            start = 1'b0;
            c++;
            if (rd_en) nrd++;
        end
        check("mid_reads_before_rst", 32'(nrd), 32'd6);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rd_en", 32'(rd_en), 32'd0);
        check("mid_rst_mac_en", 32'(mac_en), 32'd0);
        check("mid_rst_mac_clr", 32'(mac_clr), 32'd0);
        check("mid_rst_valid", 32'(result_valid), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_a_addr", 32'(a_addr), 32'd0);
        check("mid_rst_b_addr", 32'(b_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_done", 32'(done), 32'd0);
        run_job("post_rst", 24'd10, 24'd26, 0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
